sdram_bram_responder: RTL and testbench

- On-chip BRAM stand-in for the 16-bit SDRAM controller. It is the responder end of the controller-side handshake that the RISC-V memory bridge initiates.
- Presents the same request/status interface as the real controller: addr, wr_data, rd_req, wr_req, mem_size, high_byte in; rd_data, rd_data_valid, init, cur_act, cur_idle out.
- Reproduces the controller's two-beat, cycle-exact burst timing. This allows the core plus bridge to run in simulation and on boards without external DRAM.

---
 rtl/sdram_bram_responder_if.sv | 25 ++
 rtl/sdram_bram_responder.sv | 197 +++++++++++++++++++
 tb/tb_sdram_bram_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bram_responder_if.sv
// Request/status bundle between the memory bridge (master) and the SDRAM
// controller or its BRAM stand-in (slave).
interface sdram_bram_responder_if;
   logic [31:0] addr;
   logic [15:0] wr_data;
   logic        rd_req;
   logic        wr_req;
   logic [2:0]  mem_size;
   logic        high_byte;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic        init;
   logic        cur_act;
   logic        cur_idle;

   modport master (
      output addr, wr_data, rd_req, wr_req, mem_size, high_byte,
      input  rd_data, rd_data_valid, init, cur_act, cur_idle
   );

   modport slave (
      input  addr, wr_data, rd_req, wr_req, mem_size, high_byte,
      output rd_data, rd_data_valid, init, cur_act, cur_idle
   );
endinterface

// File: rtl/sdram_bram_responder.sv
// BRAM stand-in for the 16-bit SDRAM controller with cycle-exact two-beat bursts.
// Define SDRAM_BRAM_REFRESH_EN to add the refresh counter and REF state.
//
// state  | meaning
// INIT   | post-reset wait of INIT_CYCLES, init low
// IDLE   | accepting requests (wr beats rd beats refresh), cur_idle high
// ACT    | row activate for TRCD cycles, cur_act high
// RDLAT  | CAS latency padding, CL-1 cycles (skipped when CL=1)
// RD0    | first read beat, mem[A]
// RD1    | second read beat, mem[A+1]
// WR0    | first write beat into mem[A], byte lane for byte sizes
// WR1    | second write beat into mem[A+1], word size only
// PRE    | one-cycle precharge, all strobes low
// REF    | refresh for TRFC cycles, cur_idle low
module sdram_bram_responder #(
   parameter int AW           = 12,
   parameter int INIT_CYCLES  = 16,
   parameter int TRCD         = 1,
   parameter int CL           = 2,
   parameter int REF_INTERVAL = 780,
   parameter int TRFC         = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   sdram_bram_responder_if.slave  bus
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_ACT, S_RDLAT, S_RD0, S_RD1, S_WR0, S_WR1, S_PRE, S_REF
   } state_t;

   logic [15:0]   r_mem [0:(1<<AW)-1];
   state_t        r_state;
   logic [15:0]   r_cnt;
   logic          r_op_wr;
   logic [AW-1:0] r_addr;
   logic [2:0]    r_size;
   logic          r_hb;
   logic [15:0]   r_rd_data;
   logic          r_rd_valid;
   logic          r_init;
   logic          r_cur_act;
   logic          r_cur_idle;
   logic          w_ref_pend;
   logic [AW-1:0] w_addr_p1;
   logic          w_byte_sz;
   logic          w_unused_addr;

   assign w_addr_p1     = r_addr + AW'(1);
   assign w_byte_sz     = (r_size == 3'b000) || (r_size == 3'b100);
   assign w_unused_addr = ^bus.addr[31:AW];

`ifdef SDRAM_BRAM_REFRESH_EN
   logic [15:0] r_ref_cnt;
   logic        r_ref_pend;
   logic        w_ref_clr;

   assign w_ref_clr  = (r_state == S_IDLE) && !bus.wr_req && !bus.rd_req && r_ref_pend;
   assign w_ref_pend = r_ref_pend;

   // Free-running interval counter; the pending flag saturates at one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ref_cnt  <= '0;
         r_ref_pend <= 1'b0;
      end else begin
         if (w_ref_clr)
            r_ref_pend <= 1'b0;
         if (r_ref_cnt == 16'(REF_INTERVAL - 1)) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b1;
         end else begin
            r_ref_cnt <= r_ref_cnt + 16'd1;
         end
      end
   end
`else
   assign w_ref_pend = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_INIT;
         r_cnt      <= '0;
         r_op_wr    <= 1'b0;
         r_addr     <= '0;
         r_size     <= '0;
         r_hb       <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_init     <= 1'b0;
         r_cur_act  <= 1'b0;
         r_cur_idle <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_cur_act  <= 1'b0;
         r_cur_idle <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (r_cnt == 16'(INIT_CYCLES - 1)) begin
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  r_init     <= 1'b1;
                  r_cur_idle <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_IDLE: begin
               if (bus.wr_req || bus.rd_req) begin
                  r_state   <= S_ACT;
                  r_op_wr   <= bus.wr_req;
                  r_addr    <= bus.addr[AW-1:0];
                  r_size    <= bus.mem_size;
                  r_hb      <= bus.high_byte;
                  r_cnt     <= 16'(TRCD - 1);
                  r_cur_act <= 1'b1;
               end else if (w_ref_pend) begin
                  r_state <= S_REF;
                  r_cnt   <= 16'(TRFC - 1);
               end else begin
                  r_cur_idle <= 1'b1;
               end
            end
            S_ACT: begin
               if (r_cnt != '0) begin
                  r_cnt     <= r_cnt - 16'd1;
                  r_cur_act <= 1'b1;
               end else if (r_op_wr) begin
                  r_state <= S_WR0;
               end else if (CL == 1) begin
                  r_state    <= S_RD0;
                  r_rd_data  <= r_mem[r_addr];
                  r_rd_valid <= 1'b1;
               end else begin
                  r_state <= S_RDLAT;
                  r_cnt   <= 16'(CL - 2);
               end
            end
            S_RDLAT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_state    <= S_RD0;
                  r_rd_data  <= r_mem[r_addr];
                  r_rd_valid <= 1'b1;
               end
            end
            S_RD0: begin
               r_state    <= S_RD1;
               r_rd_data  <= r_mem[w_addr_p1];
               r_rd_valid <= 1'b1;
            end
            S_RD1: r_state <= S_PRE;
            S_WR0: r_state <= S_WR1;
            S_WR1: r_state <= S_PRE;
            S_PRE: begin
               r_state    <= S_IDLE;
               r_cur_idle <= 1'b1;
            end
            S_REF: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_state    <= S_IDLE;
                  r_cur_idle <= 1'b1;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   // Storage has no reset; a beat written before a reset survives it.
   // Byte writes take the byte from wr_data[7:0] and steer it to the hb lane.
   always_ff @(posedge clk) begin
      if (r_state == S_WR0) begin
         if (w_byte_sz) begin
            if (r_hb)
               r_mem[r_addr][15:8] <= bus.wr_data[7:0];
            else
               r_mem[r_addr][7:0]  <= bus.wr_data[7:0];
         end else begin
            r_mem[r_addr] <= bus.wr_data;
         end
      end else if ((r_state == S_WR1) && (r_size == 3'b010)) begin
         r_mem[w_addr_p1] <= bus.wr_data;
      end
   end

   assign bus.rd_data       = r_rd_data;
   assign bus.rd_data_valid = r_rd_valid;
   assign bus.init          = r_init;
   assign bus.cur_act       = r_cur_act;
   assign bus.cur_idle      = r_cur_idle;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Bench for sdram_bram_responder: directed vector table, reset/refresh sequences,
// and random traffic against a behavioural halfword-array model.
module tb_sdram_bram_responder;
   localparam int AW          = 12;
   localparam int DEPTH       = 1 << AW;
   localparam int INIT_CYCLES = 16;
   localparam int TRCD        = 1;
   localparam int CL          = 2;
   localparam int TRFC        = 7;
`ifdef SDRAM_BRAM_REFRESH_EN
   localparam int REF_INTERVAL = 20;
`else
   localparam int REF_INTERVAL = 780;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sdram_bram_responder_if bus();

   sdram_bram_responder #(
      .AW(AW), .INIT_CYCLES(INIT_CYCLES), .TRCD(TRCD), .CL(CL),
      .REF_INTERVAL(REF_INTERVAL), .TRFC(TRFC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_mem [DEPTH];
   bit          m_val [DEPTH];

   typedef struct {
      bit          wr;
      bit          both;
      logic [31:0] a;
      logic [2:0]  sz;
      bit          hb;
      logic [15:0] d0;
      logic [15:0] d1;
      bit          c1;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec-level write rules: byte lane from wr_data[7:0], word spans two halfwords.
   function automatic void m_write(input logic [31:0] a, input logic [2:0] sz, input bit hb,
                                   input logic [15:0] d0, input logic [15:0] d1);
      int a0 = int'(a % DEPTH);
      int a1 = (a0 + 1) % DEPTH;
      if (sz == 3'b000 || sz == 3'b100) begin
         if (m_val[a0]) begin
            if (hb) m_mem[a0][15:8] = d0[7:0];
            else    m_mem[a0][7:0]  = d0[7:0];
         end
      end else begin
         m_mem[a0] = d0;
         m_val[a0] = 1'b1;
      end
      if (sz == 3'b010) begin
         m_mem[a1] = d1;
         m_val[a1] = 1'b1;
      end
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (bus.cur_idle !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input bit hb,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input bit both, input bit linger);
      wait_idle();
      bus.addr = a; bus.mem_size = sz; bus.high_byte = hb;
      bus.wr_req = 1'b1; bus.rd_req = both; bus.wr_data = 16'($urandom);
      @(negedge clk);
      chk("wr_act", bus.cur_act, 1'b1);
      if (!linger) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
      bus.addr = $urandom; bus.mem_size = 3'($urandom); bus.high_byte = 1'($urandom);
      for (int i = 1; i < TRCD; i++) @(negedge clk);
      @(negedge clk);
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.wr_data = d0;
      chk("wr0_no_valid", bus.rd_data_valid, 1'b0);
      @(negedge clk);
      bus.wr_data = d1;
      chk("wr1_no_valid", bus.rd_data_valid, 1'b0);
      @(negedge clk);
      bus.wr_data = 16'($urandom);
      chk("wr_pre_idle", bus.cur_idle, 1'b0);
      @(negedge clk);
      chk("wr_back_idle", bus.cur_idle, 1'b1);
      m_write(a, sz, hb, d0, d1);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input bit linger,
                          input logic [15:0] e0, input logic [15:0] e1,
                          input bit c0, input bit c1);
      int k;
      wait_idle();
      bus.addr = a; bus.mem_size = sz; bus.rd_req = 1'b1;
      @(negedge clk);
      if (!linger) bus.rd_req = 1'b0;
      bus.addr = $urandom;
      k = 1;
      while (bus.rd_data_valid !== 1'b1 && k < 20) begin
         @(negedge clk);
         bus.rd_req = 1'b0;
         k++;
      end
      bus.rd_req = 1'b0;
      chk("rd_latency", 32'(k), 32'(TRCD + CL));
      if (c0) chk("rd_beat0", bus.rd_data, e0);
      @(negedge clk);
      chk("rd_beat1_valid", bus.rd_data_valid, 1'b1);
      if (c1) chk("rd_beat1", bus.rd_data, e1);
      @(negedge clk);
      chk("rd_pre_valid", bus.rd_data_valid, 1'b0);
      if (c1) chk("rd_hold", bus.rd_data, e1);
      @(negedge clk);
      chk("rd_back_idle", bus.cur_idle, 1'b1);
      chk("rd_no_second", bus.cur_act, 1'b0);
   endtask

   task automatic check_init_seq();
      int n = 0;
      chk("init_low_at_release", bus.init, 1'b0);
      while (bus.init !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("init_cycles", 32'(n), 32'(INIT_CYCLES));
      chk("idle_with_init", bus.cur_idle, 1'b1);
   endtask

   initial begin
      vec_t        tbl [20];
      logic [2:0]  szs [5];
      int          nt;

      bus.addr = '0; bus.wr_data = '0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      bus.mem_size = '0; bus.high_byte = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;

      nt = 0;
      tbl[nt++] = '{1, 0, 32'h10,        3'b010, 0, 16'h5678, 16'h1234, 0};
      tbl[nt++] = '{0, 0, 32'h10,        3'b010, 0, 16'h5678, 16'h1234, 1};
      tbl[nt++] = '{1, 0, 32'h20,        3'b001, 0, 16'hAAAA, 16'hDEAD, 0};
      tbl[nt++] = '{1, 0, 32'h20,        3'b000, 1, 16'h00CC, 16'h5555, 0};
      tbl[nt++] = '{0, 0, 32'h20,        3'b000, 0, 16'hCCAA, 16'h0000, 0};
      tbl[nt++] = '{1, 0, 32'h20,        3'b000, 0, 16'h0011, 16'h6666, 0};
      tbl[nt++] = '{0, 0, 32'h20,        3'b001, 0, 16'hCC11, 16'h0000, 0};
      tbl[nt++] = '{1, 0, 32'h31,        3'b001, 0, 16'h7777, 16'h0000, 0};
      tbl[nt++] = '{1, 0, 32'h30,        3'b001, 0, 16'h4242, 16'hBEEF, 0};
      tbl[nt++] = '{0, 0, 32'h30,        3'b101, 0, 16'h4242, 16'h7777, 1};
      tbl[nt++] = '{1, 0, 32'h0000_0FFF, 3'b010, 0, 16'hA1A1, 16'hB2B2, 0};
      tbl[nt++] = '{0, 0, 32'h0001_0FFF, 3'b010, 0, 16'hA1A1, 16'hB2B2, 1};
      tbl[nt++] = '{0, 0, 32'h0,         3'b001, 0, 16'hB2B2, 16'h0000, 0};
      tbl[nt++] = '{1, 0, 32'h40,        3'b101, 0, 16'h1234, 16'h0000, 0};
      tbl[nt++] = '{1, 0, 32'h40,        3'b100, 1, 16'h0099, 16'h0000, 0};
      tbl[nt++] = '{0, 0, 32'h40,        3'b100, 0, 16'h9934, 16'h0000, 0};
      tbl[nt++] = '{1, 1, 32'h70,        3'b010, 0, 16'h0A0B, 16'h0C0D, 0};
      tbl[nt++] = '{0, 0, 32'h70,        3'b010, 0, 16'h0A0B, 16'h0C0D, 1};

      repeat (3) @(negedge clk);
      chk("rst_rd_data", bus.rd_data, 16'h0);
      chk("rst_valid", bus.rd_data_valid, 1'b0);
      chk("rst_init", bus.init, 1'b0);
      chk("rst_cur_act", bus.cur_act, 1'b0);
      chk("rst_cur_idle", bus.cur_idle, 1'b0);
      reset = 1'b0;
      check_init_seq();

      for (int i = 0; i < nt; i++) begin
         if (tbl[i].wr)
            do_write(tbl[i].a, tbl[i].sz, tbl[i].hb, tbl[i].d0, tbl[i].d1, tbl[i].both, 1'b0);
         else
            do_read(tbl[i].a, tbl[i].sz, 1'b0, tbl[i].d0, tbl[i].d1, 1'b1, tbl[i].c1);
      end

      // Reset in the middle of a word write: beat0 lands, beat1 is lost.
      do_write(32'h51, 3'b001, 0, 16'h3333, 16'h0000, 0, 0);
      wait_idle();
      bus.addr = 32'h50; bus.mem_size = 3'b010; bus.wr_req = 1'b1;
      @(negedge clk);
      bus.wr_req = 1'b0;
      for (int i = 1; i < TRCD; i++) @(negedge clk);
      @(negedge clk);
      bus.wr_data = 16'h1111;
      @(negedge clk);
      bus.wr_data = 16'h2222;
      #1 reset = 1'b1;
      #1;
      chk("midrst_init", bus.init, 1'b0);
      chk("midrst_idle", bus.cur_idle, 1'b0);
      chk("midrst_valid", bus.rd_data_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      m_mem[32'h50] = 16'h1111;
      m_val[32'h50] = 1'b1;
      check_init_seq();
      do_read(32'h50, 3'b010, 1'b0, 16'h1111, 16'h3333, 1'b1, 1'b1);

`ifdef SDRAM_BRAM_REFRESH_EN
      begin
         int n = 0;
         int k;
         while (bus.cur_idle === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("ref_entered", bus.cur_idle, 1'b0);
         bus.addr = 32'h10; bus.mem_size = 3'b010; bus.rd_req = 1'b1;
         n = 0;
         while (bus.cur_idle !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
         end
         chk("ref_length", 32'(n), 32'(TRFC));
         @(negedge clk);
         chk("ref_then_act", bus.cur_act, 1'b1);
         bus.rd_req = 1'b0;
         k = 1;
         while (bus.rd_data_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("ref_rd_latency", 32'(k), 32'(TRCD + CL));
         chk("ref_rd_beat0", bus.rd_data, 16'h5678);
         @(negedge clk);
         chk("ref_rd_beat1", bus.rd_data, 16'h1234);
         @(negedge clk);
      end
`endif

      szs[0] = 3'b000; szs[1] = 3'b001; szs[2] = 3'b010; szs[3] = 3'b100; szs[4] = 3'b101;
      for (int i = 0; i < 150; i++) begin
         int          idx = $urandom_range(0, 11);
         logic [31:0] a   = (idx < 8) ? 32'(idx + 8'h80) : 32'(DEPTH - 12 + idx);
         int          a0;
         int          a1;
         logic [2:0]  sz  = szs[$urandom_range(0, 4)];
         bit          lng = 1'($urandom);
         a  = a | ($urandom & 32'hFFFF_F000);
         a0 = int'(a % DEPTH);
         a1 = (a0 + 1) % DEPTH;
         if ($urandom_range(0, 1) == 1)
            do_write(a, sz, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), lng);
         else
            do_read(a, sz, lng, m_mem[a0], m_mem[a1], m_val[a0], m_val[a1]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
